// File: rtl/router_pkg.sv
// Shared router definitions: packet field map and hop-decrement helper.
package router_pkg;

   localparam int unsigned PKT_W      = 16;
   localparam int unsigned PAYLOAD_HI = 15;
   localparam int unsigned PAYLOAD_LO = 8;
   localparam int unsigned DX_HI      = 7;
   localparam int unsigned DX_LO      = 4;
   localparam int unsigned DY_HI      = 3;
   localparam int unsigned DY_LO      = 0;

   typedef struct packed {
      logic [PAYLOAD_HI-PAYLOAD_LO:0] payload;
      logic [DX_HI-DX_LO:0]           dx;
      logic [DY_HI-DY_LO:0]           dy;
   } pkt_t;

   // Consume one eastbound hop; callers guarantee dx != 0.
   function automatic logic [PKT_W-1:0] dec_dx(input logic [PKT_W-1:0] p);
      pkt_t r;
      r    = pkt_t'(p);
      r.dx = r.dx - 4'd1;
      return r;
   endfunction

endpackage

// File: rtl/rx_fifo.sv
// Generic first-word-fall-through FIFO; head is always visible on pop_data.
module rx_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/east_link_receiver.sv
// Eastbound link receiver: hop decrement, dx==0 filtering, FWFT buffering.
// Optional rx/drop statistics counters under RX_STATS_EN.
module east_link_receiver
   import router_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PKT_W-1:0] link_packet,
   input  logic             link_valid,
   output logic             link_ready,
   output logic [PKT_W-1:0] pkt_out,
   output logic             pkt_valid,
   input  logic             pkt_ready,
   output logic             pkt_is_local,
   output logic             hop_err
`ifdef RX_STATS_EN
   ,
   output logic [15:0]      rx_count,
   output logic [15:0]      drop_count
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty, fifo_pop;
   logic          accept, dx_zero, store, drop;
   logic          hop_err_q, hop_err_d;

   always_comb begin
      accept    = link_valid && !fifo_full;
      dx_zero   = (link_packet[DX_HI:DX_LO] == '0);
      store     = accept && !dx_zero;
      drop      = accept && dx_zero;
      fifo_pop  = pkt_ready && !fifo_empty;
      hop_err_d = hop_err_q || drop;
   end

   rx_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (store),
      .push_data (dec_dx(link_packet)),
      .pop       (fifo_pop),
      .pop_data  (pkt_out),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign link_ready   = !fifo_full;
   assign pkt_valid    = (fifo_count != '0);
   assign pkt_is_local = (pkt_out[DX_HI:DX_LO] == '0);
   assign hop_err      = hop_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hop_err_q <= 1'b0;
      else        hop_err_q <= hop_err_d;
   end

`ifdef RX_STATS_EN
   localparam int unsigned STAT_W = 16;

   logic [STAT_W-1:0] rx_count_q, rx_count_d;
   logic [STAT_W-1:0] drop_count_q, drop_count_d;
   logic              drop_event;

   // Saturating counters; a refused offer and a dx==0 drop never coincide.
   always_comb begin
      drop_event   = drop || (link_valid && fifo_full);
      rx_count_d   = rx_count_q;
      drop_count_d = drop_count_q;
      if (store && (rx_count_q != '1))        rx_count_d   = rx_count_q + STAT_W'(1);
      if (drop_event && (drop_count_q != '1)) drop_count_d = drop_count_q + STAT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_count_q   <= '0;
         drop_count_q <= '0;
      end else begin
         rx_count_q   <= rx_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign rx_count   = rx_count_q;
   assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_east_link_receiver.sv
// Self-checking bench for east_link_receiver against a queue-based model.
module tb_east_link_receiver;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] link_packet;
   logic        link_valid;
   logic        link_ready;
   logic [15:0] pkt_out;
   logic        pkt_valid;
   logic        pkt_ready;
   logic        pkt_is_local;
   logic        hop_err;
`ifdef RX_STATS_EN
   logic [15:0] rx_count;
   logic [15:0] drop_count;
`endif

   east_link_receiver #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .link_packet  (link_packet),
      .link_valid   (link_valid),
      .link_ready   (link_ready),
      .pkt_out      (pkt_out),
      .pkt_valid    (pkt_valid),
      .pkt_ready    (pkt_ready),
      .pkt_is_local (pkt_is_local),
      .hop_err      (hop_err)
`ifdef RX_STATS_EN
      ,
      .rx_count     (rx_count),
      .drop_count   (drop_count)
`endif
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [15:0] mq[$];
   logic        m_err;
   int unsigned m_rx, m_drop;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic model_clear();
      mq.delete();
      m_err  = 1'b0;
      m_rx   = 0;
      m_drop = 0;
   endtask

   // Drive one cycle, advance the model at the edge, return #1 after it.
   task automatic cyc(input logic v, input logic [15:0] p, input logic r);
      bit acc, popd;
      link_valid  = v;
      link_packet = p;
      pkt_ready   = r;
      @(posedge clk);
      acc  = v && (mq.size() < DEPTH);
      popd = r && (mq.size() != 0);
      if (popd) void'(mq.pop_front());
      if (acc && p[7:4] != 4'd0) begin
         mq.push_back({p[15:8], p[7:4] - 4'd1, p[3:0]});
         if (m_rx < 16'hFFFF) m_rx++;
      end
      if ((acc && p[7:4] == 4'd0) || (v && !acc)) begin
         if (m_drop < 16'hFFFF) m_drop++;
      end
      if (acc && p[7:4] == 4'd0) m_err = 1'b1;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      link_valid = 1'b0; link_packet = '0; pkt_ready = 1'b0;
      model_clear();
      #12;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      link_valid = 1'b0; link_packet = '0; pkt_ready = 1'b0;
      model_clear();
      #3;
      n_cmp++; if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", pkt_valid); end
      n_cmp++; if (link_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", link_ready); end
      n_cmp++; if (hop_err !== 1'b0) begin n_fail++; $display("FAIL reset_hop_err got %b want 0", hop_err); end
      n_cmp++; if (pkt_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pkt_out got %h want 0000", pkt_out); end
      #10; rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 16'h0000, 1'b1);
         n_cmp++; if (pkt_valid !== 1'b0 || link_ready !== 1'b1 || hop_err !== 1'b0) begin
            n_fail++; $display("FAIL idle v/r/e got %b%b%b want 010", pkt_valid, link_ready, hop_err);
         end
      end
`ifdef RX_STATS_EN
      n_cmp++; if (rx_count !== 16'd0 || drop_count !== 16'd0) begin
         n_fail++; $display("FAIL reset_stats got %0d/%0d want 0/0", rx_count, drop_count);
      end
`endif
   endtask

   task automatic test_single();
      cyc(1'b1, 16'hA530, 1'b0);
      n_cmp++; if (pkt_valid !== 1'b1 || pkt_out !== 16'hA520 || pkt_is_local !== 1'b0) begin
         n_fail++; $display("FAIL single_head got v=%b %h l=%b want v=1 a520 l=0", pkt_valid, pkt_out, pkt_is_local);
      end
      cyc(1'b1, 16'h0011, 1'b0);
      n_cmp++; if (pkt_out !== 16'hA520) begin n_fail++; $display("FAIL single_hold got %h want a520", pkt_out); end
      cyc(1'b0, 16'h0000, 1'b1);
      n_cmp++; if (pkt_valid !== 1'b1 || pkt_out !== 16'h0001 || pkt_is_local !== 1'b1) begin
         n_fail++; $display("FAIL single_second got v=%b %h l=%b want v=1 0001 l=1", pkt_valid, pkt_out, pkt_is_local);
      end
      cyc(1'b0, 16'h0000, 1'b1);
      n_cmp++; if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got %b want 0", pkt_valid); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, {8'(8'h10 + i), 4'h2, 4'(i)}, 1'b0);
         n_cmp++; if (link_ready !== (i < DEPTH - 1)) begin
            n_fail++; $display("FAIL fill_ready[%0d] got %b want %b", i, link_ready, (i < DEPTH - 1));
         end
      end
      cyc(1'b1, 16'hEE2E, 1'b0);
      n_cmp++; if (link_ready !== 1'b0 || pkt_out !== 16'h1010 || mq.size() != DEPTH) begin
         n_fail++; $display("FAIL fill_overflow got r=%b %h want r=0 1010", link_ready, pkt_out);
      end
`ifdef RX_STATS_EN
      n_cmp++; if (drop_count !== 16'd1 || rx_count !== 16'(m_rx)) begin
         n_fail++; $display("FAIL fill_stats got rx=%0d drop=%0d want rx=%0d drop=1", rx_count, drop_count, m_rx);
      end
`endif
   endtask

   task automatic test_full_pop();
      // Offer while full and popping: the offer must be lost (bubble).
      cyc(1'b1, 16'h7727, 1'b1);
      n_cmp++; if (link_ready !== 1'b1 || pkt_out !== mq[0]) begin
         n_fail++; $display("FAIL fullpop_ready got r=%b %h want r=1 %h", link_ready, pkt_out, mq[0]);
      end
      cyc(1'b1, 16'h5525, 1'b0);
      n_cmp++; if (link_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_refill got %b want 0", link_ready); end
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++; if (pkt_valid !== 1'b1 || pkt_out !== mq[0]) begin
            n_fail++; $display("FAIL fullpop_order[%0d] got %h want %h", i, pkt_out, mq[0]);
         end
         cyc(1'b0, 16'h0000, 1'b1);
      end
      n_cmp++; if (pkt_valid !== 1'b0 || mq.size() != 0) begin
         n_fail++; $display("FAIL fullpop_empty got %b want 0", pkt_valid);
      end
`ifdef RX_STATS_EN
      n_cmp++; if (drop_count !== 16'(m_drop) || rx_count !== 16'(m_rx)) begin
         n_fail++; $display("FAIL fullpop_stats got %0d/%0d want %0d/%0d", rx_count, drop_count, m_rx, m_drop);
      end
`endif
   endtask

   task automatic test_simul();
      logic [15:0] p;
      cyc(1'b1, 16'h0143, 1'b0);
      cyc(1'b1, 16'h0254, 1'b0);
      for (int i = 0; i < 6; i++) begin
         p = {8'($urandom_range(255)), 4'($urandom_range(15, 1)), 4'($urandom_range(15))};
         cyc(1'b1, p, 1'b1);
         n_cmp++; if (pkt_valid !== 1'b1 || link_ready !== 1'b1 || pkt_out !== mq[0] || mq.size() != 2) begin
            n_fail++; $display("FAIL simul[%0d] got v=%b r=%b %h want v=1 r=1 %h", i, pkt_valid, link_ready, pkt_out, mq[0]);
         end
      end
      cyc(1'b0, 16'h0000, 1'b1);
      cyc(1'b0, 16'h0000, 1'b1);
   endtask

   task automatic test_hop_err();
      cyc(1'b1, 16'h0003, 1'b0);
      n_cmp++; if (pkt_valid !== 1'b0 || hop_err !== 1'b1) begin
         n_fail++; $display("FAIL hop_drop got v=%b e=%b want v=0 e=1", pkt_valid, hop_err);
      end
      cyc(1'b1, 16'h1234, 1'b0);
      cyc(1'b0, 16'h0000, 1'b1);
      cyc(1'b0, 16'h0000, 1'b0);
      n_cmp++; if (hop_err !== 1'b1 || pkt_valid !== 1'b0) begin
         n_fail++; $display("FAIL hop_sticky got e=%b v=%b want e=1 v=0", hop_err, pkt_valid);
      end
   endtask

   task automatic test_reset_mid();
      cyc(1'b1, 16'h3131, 1'b0);
      cyc(1'b1, 16'h4242, 1'b0);
      #2; rst_n = 1'b0; #1;
      model_clear();
      n_cmp++; if (pkt_valid !== 1'b0 || link_ready !== 1'b1 || hop_err !== 1'b0 || pkt_out !== 16'h0000) begin
         n_fail++; $display("FAIL midreset got v=%b r=%b e=%b %h want 0 1 0 0000", pkt_valid, link_ready, hop_err, pkt_out);
      end
      link_valid = 1'b0; pkt_ready = 1'b0;
      #10; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [15:0] p;
      logic        v, r;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(3) != 0);
         r = ($urandom_range(2) != 0);
         p = 16'($urandom);
         if ($urandom_range(15) == 0) p[7:4] = 4'd0;
         else if (p[7:4] == 4'd0)     p[7:4] = 4'd1;
         cyc(v, p, r);
         n_cmp++; if (pkt_valid !== (mq.size() != 0) || link_ready !== (mq.size() < DEPTH) || hop_err !== m_err) begin
            n_fail++; $display("FAIL rand_flags[%0d] got v=%b r=%b e=%b want size=%0d e=%b", i, pkt_valid, link_ready, hop_err, mq.size(), m_err);
         end
         if (mq.size() != 0) begin
            n_cmp++; if (pkt_out !== mq[0] || pkt_is_local !== (mq[0][7:4] == 4'd0)) begin
               n_fail++; $display("FAIL rand_head[%0d] got %h l=%b want %h", i, pkt_out, pkt_is_local, mq[0]);
            end
         end
`ifdef RX_STATS_EN
         n_cmp++; if (rx_count !== 16'(m_rx) || drop_count !== 16'(m_drop)) begin
            n_fail++; $display("FAIL rand_stats[%0d] got %0d/%0d want %0d/%0d", i, rx_count, drop_count, m_rx, m_drop);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_full_pop();
      test_simul();
      test_hop_err();
      test_reset_mid();
      test_random();
      do_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
